diagnosis_event_packetizer: RTL and testbench

Downstream stage of the system diagnosis event logic. It takes fixed-format diagnosis event records (type, 32-bit timestamp, 0..MAX_PKT_LEN-5 payload words), buffers them in a small FIFO, and serializes each record into one debug packet on the dii_flit debug interface. Events arrive from non-stallable CPU trace logic, so the block never back-pressures its source. Events that find the FIFO full are dropped and counted. The count is reported in a dedicated overflow packet.

---
 rtl/diagnosis_event_packetizer.sv | 225 ++++++++++++++++++++++
 tb/tb_diagnosis_event_packetizer.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/diagnosis_event_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : diagnosis_event_packetizer (with package dii_package)
// Description : Buffers diagnosis event records in a small FIFO and serializes
//               each one into a debug packet on a dii_flit interface. The
//               event source cannot be stalled, so events that find the FIFO
//               full are dropped and counted. The drop count is reported in a
//               dedicated overflow packet, which takes priority over queued
//               events.
// Ports       : clk, rst_n (async, active-low)
//               id              - own debug address (packet source)
//               enable          - gates event capture only
//               ev_valid/ev_type/ev_len/ev_timestamp/ev_data - event record
//               debug_out       - packet flits {valid, last, data}
//               debug_out_ready - sink accepts the current flit
//               lost_count      - drops not yet reported
// Revision    : 1.0 - initial release
// ============================================================================

package dii_package;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module diagnosis_event_packetizer
  import dii_package::*;
#(
  parameter int          MAX_PKT_LEN = 8,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEST        = 16'h0000,
  localparam int         PW          = MAX_PKT_LEN - 5,
  localparam int         LW          = $clog2(PW + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [9:0]       id,
  input  logic             enable,
  input  logic             ev_valid,
  input  logic [7:0]       ev_type,
  input  logic [LW-1:0]    ev_len,
  input  logic [31:0]      ev_timestamp,
  input  logic [PW*16-1:0] ev_data,
  output dii_flit          debug_out,
  input  logic             debug_out_ready,
  output logic [15:0]      lost_count
);

  localparam int            AW       = $clog2(FIFO_DEPTH);
  localparam int            IW       = $clog2(MAX_PKT_LEN);
  localparam logic [LW-1:0] PW_LEN   = LW'(PW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVT  = 2'd1,
    ST_OVF  = 2'd2
  } state_t;

  // Event storage (no reset needed: validity is tracked by the pointers)
  logic [7:0]       type_mem [FIFO_DEPTH];
  logic [LW-1:0]    len_mem  [FIFO_DEPTH];
  logic [31:0]      ts_mem   [FIFO_DEPTH];
  logic [PW*16-1:0] data_mem [FIFO_DEPTH];

  state_t        state_q,  state_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]   lost_q,   lost_d;
  logic [15:0]   snap_q,   snap_d;

  logic             fifo_empty;
  logic             fifo_full;
  logic             accept;
  logic             pop;
  logic             capture;
  logic             wr_en;
  logic             drop;
  logic             take_ovf;
  logic [15:0]      lost_base;
  logic [LW-1:0]    len_clamped;
  logic [7:0]       head_type;
  logic [LW-1:0]    head_len;
  logic [31:0]      head_ts;
  logic [PW*16-1:0] head_data;
  logic [IW-1:0]    evt_last_idx;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign head_type    = type_mem[rd_ptr_q[AW-1:0]];
  assign head_len     = len_mem[rd_ptr_q[AW-1:0]];
  assign head_ts      = ts_mem[rd_ptr_q[AW-1:0]];
  assign head_data    = data_mem[rd_ptr_q[AW-1:0]];
  assign evt_last_idx = IW'(4) + IW'(head_len);

  assign len_clamped = (ev_len > PW_LEN) ? PW_LEN : ev_len;

  // Flit output: decoded from the registered state, flit index and either
  // the FIFO head or the overflow snapshot.
  always_comb begin
    debug_out = '0;
    case (state_q)
      ST_EVT: begin
        debug_out.valid = 1'b1;
        debug_out.last  = (idx_q == evt_last_idx);
        if (idx_q == IW'(0))      debug_out.data = DEST;
        else if (idx_q == IW'(1)) debug_out.data = {6'b0, id};
        else if (idx_q == IW'(2)) debug_out.data = {4'h2, 4'h0, head_type};
        else if (idx_q == IW'(3)) debug_out.data = head_ts[15:0];
        else if (idx_q == IW'(4)) debug_out.data = head_ts[31:16];
        else begin
          for (int k = 0; k < PW; k++) begin
            if (idx_q == IW'(5 + k)) debug_out.data = head_data[16*k +: 16];
          end
        end
      end
      ST_OVF: begin
        debug_out.valid = 1'b1;
        debug_out.last  = (idx_q == IW'(3));
        if (idx_q == IW'(0))      debug_out.data = DEST;
        else if (idx_q == IW'(1)) debug_out.data = {6'b0, id};
        else if (idx_q == IW'(2)) debug_out.data = {4'h2, 4'h1, 8'h00};
        else                      debug_out.data = snap_q;
      end
      default: ;
    endcase
  end

  assign accept     = debug_out.valid && debug_out_ready;
  assign lost_count = lost_q;

  // Packet sequencing and FIFO read side
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    pop      = 1'b0;
    take_ovf = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (lost_q != 16'd0) begin
          state_d  = ST_OVF;
          snap_d   = lost_q;
          take_ovf = 1'b1;
        end else if (!fifo_empty) begin
          state_d = ST_EVT;
        end
      end
      ST_EVT: begin
        if (accept) begin
          if (debug_out.last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            pop     = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_OVF: begin
        if (accept) begin
          if (debug_out.last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Capture side. A pop in the same cycle frees an entry, so a full FIFO can
  // still accept the incoming event.
  always_comb begin
    capture   = ev_valid && enable;
    wr_en     = capture && (!fifo_full || pop);
    drop      = capture && !wr_en;
    wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(pop);
    // The snapshot clears the counter; a drop in the same cycle restarts it at 1.
    lost_base = take_ovf ? 16'd0 : lost_q;
    lost_d    = lost_base;
    if (drop && (lost_base != 16'hFFFF)) lost_d = lost_base + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      type_mem[wr_ptr_q[AW-1:0]] <= ev_type;
      len_mem[wr_ptr_q[AW-1:0]]  <= len_clamped;
      ts_mem[wr_ptr_q[AW-1:0]]   <= ev_timestamp;
      data_mem[wr_ptr_q[AW-1:0]] <= ev_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lost_q   <= '0;
      snap_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lost_q   <= lost_d;
      snap_q   <= snap_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_diagnosis_event_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_diagnosis_event_packetizer
// Description : Self-checking bench for diagnosis_event_packetizer. A
//               packet-level reference model (event queue, flit list of the
//               packet in flight, drop counter) predicts the flit stream and
//               lost_count every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diagnosis_event_packetizer;
  import dii_package::*;

  localparam int          MAX_PKT_LEN = 8;
  localparam int          FIFO_DEPTH  = 4;
  localparam int          PW          = MAX_PKT_LEN - 5;
  localparam int          LW          = $clog2(PW + 1);
  localparam logic [15:0] DEST        = 16'h0000;

  logic             clk             = 1'b0;
  logic             rst_n           = 1'b0;
  logic [9:0]       id              = 10'h003;
  logic             enable          = 1'b0;
  logic             ev_valid        = 1'b0;
  logic [7:0]       ev_type         = '0;
  logic [LW-1:0]    ev_len          = '0;
  logic [31:0]      ev_timestamp    = '0;
  logic [PW*16-1:0] ev_data         = '0;
  logic             debug_out_ready = 1'b0;
  dii_flit          debug_out;
  logic [15:0]      lost_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  diagnosis_event_packetizer #(
    .MAX_PKT_LEN (MAX_PKT_LEN),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .DEST        (DEST)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id              (id),
    .enable          (enable),
    .ev_valid        (ev_valid),
    .ev_type         (ev_type),
    .ev_len          (ev_len),
    .ev_timestamp    (ev_timestamp),
    .ev_data         (ev_data),
    .debug_out       (debug_out),
    .debug_out_ready (debug_out_ready),
    .lost_count      (lost_count)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]       t;
    logic [LW-1:0]    len;
    logic [31:0]      ts;
    logic [PW*16-1:0] data;
  } ev_t;

  ev_t         m_fifo[$];
  logic [15:0] m_pkt[$];
  bit          m_busy   = 1'b0;
  bit          m_is_evt = 1'b0;
  logic [15:0] m_lost   = '0;
  logic [16:0] got[$];

  task automatic model_reset();
    m_fifo.delete();
    m_pkt.delete();
    m_busy   = 1'b0;
    m_is_evt = 1'b0;
    m_lost   = '0;
  endtask

  task automatic model_step();
    bit          acc, popping, start_ovf, start_evt, drop;
    int          pre_size;
    logic [15:0] base, tmp;
    ev_t         e;
    if (!rst_n) begin
      model_reset();
    end else begin
      pre_size  = m_fifo.size();
      acc       = m_busy && debug_out_ready;
      popping   = acc && m_is_evt && (m_pkt.size() == 1);
      start_ovf = !m_busy && (m_lost != 16'd0);
      start_evt = !m_busy && !start_ovf && (pre_size != 0);
      drop      = 1'b0;
      base      = start_ovf ? 16'd0 : m_lost;
      if (acc) begin
        tmp = m_pkt.pop_front();
        if (m_pkt.size() == 0) begin
          m_busy = 1'b0;
          if (m_is_evt) e = m_fifo.pop_front();
        end
      end
      if (start_ovf) begin
        m_pkt.delete();
        m_pkt.push_back(DEST);
        m_pkt.push_back({6'b0, id});
        m_pkt.push_back(16'h2100);
        m_pkt.push_back(m_lost);
        m_busy   = 1'b1;
        m_is_evt = 1'b0;
      end else if (start_evt) begin
        e = m_fifo[0];
        m_pkt.delete();
        m_pkt.push_back(DEST);
        m_pkt.push_back({6'b0, id});
        m_pkt.push_back({8'h20, e.t});
        m_pkt.push_back(e.ts[15:0]);
        m_pkt.push_back(e.ts[31:16]);
        for (int k = 0; k < int'(e.len); k++) m_pkt.push_back(e.data[16*k +: 16]);
        m_busy   = 1'b1;
        m_is_evt = 1'b1;
      end
      if (ev_valid && enable) begin
        if (pre_size < FIFO_DEPTH || popping) begin
          e.t    = ev_type;
          e.len  = (int'(ev_len) > PW) ? LW'(PW) : ev_len;
          e.ts   = ev_timestamp;
          e.data = ev_data;
          m_fifo.push_back(e);
        end else begin
          drop = 1'b1;
        end
      end
      m_lost = (drop && base != 16'hFFFF) ? base + 16'd1 : base;
    end
  endtask

  function automatic dii_flit exp_flit();
    dii_flit f;
    f = '0;
    if (m_busy) begin
      f.valid = 1'b1;
      f.last  = (m_pkt.size() == 1);
      f.data  = m_pkt[0];
    end
    return f;
  endfunction

  function automatic bit model_idle();
    return !m_busy && (m_fifo.size() == 0) && (m_lost == 16'd0);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic rand_event();
    ev_type      = 8'($urandom);
    ev_len       = LW'($urandom_range(0, PW));
    ev_timestamp = $urandom;
    for (int k = 0; k < PW; k++) ev_data[16*k +: 16] = 16'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; debug_out_ready = 1'b1;
    rand_event(); ev_valid = 1'b1;
    repeat (3) cycle();
    checks++;
    if (debug_out !== '0) begin
      errors++; $display("FAIL reset_flit: got %h, expected 0", debug_out);
    end
    checks++;
    if (lost_count !== 16'd0) begin
      errors++; $display("FAIL reset_lost: got %h, expected 0", lost_count);
    end
    ev_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) cycle();
    checks++;
    if (debug_out.valid !== 1'b0) begin
      errors++; $display("FAIL reset_nocapture: valid got %b, expected 0", debug_out.valid);
    end
  endtask

  task automatic test_single();
    logic [15:0] exp_d [7] = '{16'h0000, 16'h0003, 16'h2005, 16'h5678, 16'h1234, 16'hAAAA, 16'hBBBB};
    dii_flit ef;
    got.delete();
    ev_type = 8'h05; ev_timestamp = 32'h12345678; ev_len = LW'(2);
    ev_data = 48'h0000_BBBB_AAAA;
    enable = 1'b1; debug_out_ready = 1'b1; ev_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) ev_valid = 1'b0;
      if (debug_out.valid && debug_out_ready) got.push_back({debug_out.last, debug_out.data});
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL single_model cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", i, debug_out, lost_count, ef, m_lost);
      end
      if (i < 2) begin
        checks++;
        if (debug_out.valid !== (i == 1)) begin
          errors++; $display("FAIL single_latency cyc %0d: valid got %b, expected %b", i, debug_out.valid, (i == 1));
        end
      end
    end
    checks++;
    if (got.size() != 7) begin
      errors++; $display("FAIL single_len: got %0d flits, expected 7", got.size());
    end
    for (int k = 0; k < got.size() && k < 7; k++) begin
      checks++;
      if (got[k] !== {(k == 6), exp_d[k]}) begin
        errors++; $display("FAIL single_flit%0d: got %h, expected %h", k, got[k], {(k == 6), exp_d[k]});
      end
    end
  endtask

  task automatic test_zero_toggle();
    dii_flit ef, prev;
    bit      stall;
    got.delete();
    rand_event(); ev_len = '0; ev_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (i == 1) ev_valid = 1'b0;
      debug_out_ready = (i % 2 == 1);
      if (debug_out.valid && debug_out_ready) got.push_back({debug_out.last, debug_out.data});
      stall = debug_out.valid && !debug_out_ready;
      prev  = debug_out;
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL toggle_model cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", i, debug_out, lost_count, ef, m_lost);
      end
      if (stall) begin
        checks++;
        if (debug_out !== prev) begin
          errors++; $display("FAIL toggle_hold cyc %0d: got %h, expected %h", i, debug_out, prev);
        end
      end
    end
    checks++;
    if (got.size() != 5) begin
      errors++; $display("FAIL toggle_len: got %0d flits, expected 5", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k][16] !== (k == 4)) begin
        errors++; $display("FAIL toggle_last%0d: got %b, expected %b", k, got[k][16], (k == 4));
      end
    end
  endtask

  task automatic test_overflow();
    dii_flit     ef;
    int          n, p;
    logic [16:0] exp_ovf [4] = '{17'h0_0000, 17'h0_0003, 17'h0_2100, 17'h1_0003};
    got.delete();
    debug_out_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin rand_event(); ev_valid = 1'b1; end
      else ev_valid = 1'b0;
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL ovf_fill cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", i, debug_out, lost_count, ef, m_lost);
      end
    end
    checks++;
    if (lost_count !== 16'd3) begin
      errors++; $display("FAIL ovf_lost3: got %0d, expected 3", lost_count);
    end
    debug_out_ready = 1'b1;
    n = 0;
    while (!model_idle() && n < 200) begin
      if (debug_out.valid && debug_out_ready) got.push_back({debug_out.last, debug_out.data});
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL ovf_drain cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", n, debug_out, lost_count, ef, m_lost);
      end
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL ovf_timeout: got %0d cycles, expected < 200", n);
    end
    p = 0;
    while (p < got.size() && got[p][16] !== 1'b1) p++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (p + 1 + k >= got.size() || got[p+1+k] !== exp_ovf[k]) begin
        errors++;
        $display("FAIL ovf_pkt_flit%0d: got %h, expected %h", k, (p + 1 + k < got.size()) ? got[p+1+k] : 17'h0, exp_ovf[k]);
      end
    end
    checks++;
    if (lost_count !== 16'd0) begin
      errors++; $display("FAIL ovf_lost_cleared: got %0d, expected 0", lost_count);
    end
  endtask

  task automatic test_snapshot_drop();
    dii_flit     ef;
    int          n, start;
    logic [15:0] ovf_vals[$];
    got.delete();
    debug_out_ready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rand_event(); ev_valid = 1'b1;
      cycle();
    end
    debug_out_ready = 1'b1;
    n = 0;
    // keep events flowing until the overflow snapshot is taken
    while (!(m_busy && !m_is_evt) && n < 50) begin
      rand_event(); ev_valid = 1'b1;
      if (debug_out.valid && debug_out_ready) got.push_back({debug_out.last, debug_out.data});
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL snap_fill cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", n, debug_out, lost_count, ef, m_lost);
      end
      n++;
    end
    ev_valid = 1'b0;
    checks++;
    if (lost_count !== 16'd1) begin
      errors++; $display("FAIL snap_lost1: got %0d, expected 1", lost_count);
    end
    n = 0;
    while (!model_idle() && n < 200) begin
      if (debug_out.valid && debug_out_ready) got.push_back({debug_out.last, debug_out.data});
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL snap_drain cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", n, debug_out, lost_count, ef, m_lost);
      end
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL snap_timeout: got %0d cycles, expected < 200", n);
    end
    start = 0;
    for (int k = 0; k < got.size(); k++) begin
      if (got[k][16]) begin
        if (k - start == 3 && got[start+2][15:0] == 16'h2100) ovf_vals.push_back(got[k][15:0]);
        start = k + 1;
      end
    end
    checks++;
    if (ovf_vals.size() != 2) begin
      errors++; $display("FAIL snap_ovf_count: got %0d overflow packets, expected 2", ovf_vals.size());
    end else begin
      checks++;
      if (ovf_vals[1] !== 16'd1) begin
        errors++; $display("FAIL snap_second_count: got %0d, expected 1", ovf_vals[1]);
      end
    end
  endtask

  task automatic test_enable_off();
    enable = 1'b0; debug_out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 10) begin rand_event(); ev_valid = 1'b1; end
      else ev_valid = 1'b0;
      cycle();
      checks++;
      if (debug_out.valid !== 1'b0 || lost_count !== 16'd0) begin
        errors++;
        $display("FAIL enable_off cyc %0d: got valid=%b lost=%0d, expected valid=0 lost=0", i, debug_out.valid, lost_count);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    dii_flit ef;
    int      n;
    enable = 1'b1; debug_out_ready = 1'b1;
    rand_event(); ev_len = LW'(1); ev_valid = 1'b1;
    cycle();
    rand_event();
    cycle();
    ev_valid = 1'b0;
    n = 0;
    while (!(m_busy && m_is_evt && m_pkt.size() == 3) && n < 20) begin
      cycle(); n++;
    end
    checks++;
    if (n >= 20 || debug_out.valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_reach: got valid=%b after %0d cycles, expected valid=1", debug_out.valid, n);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (debug_out !== '0 || lost_count !== 16'd0) begin
      errors++; $display("FAIL rstmid_async: got flit=%h lost=%0d, expected 0/0", debug_out, lost_count);
    end
    cycle(); cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (debug_out.valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_empty cyc %0d: valid got %b, expected 0", i, debug_out.valid);
      end
    end
    got.delete();
    rand_event(); ev_valid = 1'b1;
    n = 0;
    do begin
      if (n == 1) ev_valid = 1'b0;
      if (debug_out.valid && debug_out_ready) got.push_back({debug_out.last, debug_out.data});
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL rstmid_new cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", n, debug_out, lost_count, ef, m_lost);
      end
      n++;
    end while ((!model_idle() || n < 2) && n < 30);
    checks++;
    if (got.size() != 5 + int'(ev_len) || got[got.size()-1][16] !== 1'b1) begin
      errors++; $display("FAIL rstmid_pkt_len: got %0d flits, expected %0d ending in last", got.size(), 5 + int'(ev_len));
    end
  endtask

  task automatic test_random();
    dii_flit ef;
    int      n;
    for (int i = 0; i < 400; i++) begin
      rand_event();
      ev_valid        = ($urandom_range(0, 2) == 0);
      enable          = ($urandom_range(0, 7) != 0);
      debug_out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL random cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", i, debug_out, lost_count, ef, m_lost);
      end
    end
    ev_valid = 1'b0; enable = 1'b1; debug_out_ready = 1'b1;
    n = 0;
    while (!model_idle() && n < 200) begin
      cycle();
      ef = exp_flit(); checks++;
      if (debug_out !== ef || lost_count !== m_lost) begin
        errors++;
        $display("FAIL random_drain cyc %0d: got flit=%h lost=%h, expected flit=%h lost=%h", n, debug_out, lost_count, ef, m_lost);
      end
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL random_timeout: got %0d cycles, expected < 200", n);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_zero_toggle();
    test_overflow();
    test_snapshot_drop();
    test_enable_off();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
